// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer
// Description : Parametrised programmable interval timer. Counts enabled
//               clock cycles through an optional prescaler and emits a
//               one-cycle 'out' pulse every load_value x DIV enabled cycles.
//               Supports periodic (auto-reload) and one-shot modes, an
//               explicit load strobe and live reload sampling at wrap.
//
// Parameters  : WIDTH - width of the period counter and load_value
//               DIV   - prescale divisor (>= 1)
//
// Ports       : clock      in   system clock, rising edge
//               reset      in   asynchronous active-high reset
//               count_en   in   counting enable, low freezes prescaler/counter
//               load       in   single-cycle (re)start strobe
//               load_value in   period in prescaled ticks, 0 = stop
//               periodic   in   1 = auto-reload, 0 = one-shot (sampled at load)
//               out        out  registered expiry pulse
//               busy       out  high while running
//               done       out  high after one-shot expiry until next load
//               count      out  current counter value
//
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer #(
    parameter int WIDTH = 9,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             count_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             periodic,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    // Prescaler width; held at 1 for DIV=1 so declarations stay legal even
    // though no prescaler register is built in that case.
    localparam int C_PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_out;
    logic             w_out_nxt;

    logic             w_run_en;   // prescaler advances this cycle
    logic             w_pre_last; // prescaler sits on its final phase
    logic             w_tick;     // one prescaled tick of the period counter

    assign w_run_en = count_en && (r_state == S_RUN);
    assign w_tick   = w_run_en && w_pre_last;

    // ------------------------------------------------------------------------
    // Prescaler: only exists when DIV > 1; otherwise every enabled RUN cycle
    // is a tick.
    // ------------------------------------------------------------------------
    generate
        if (DIV > 1) begin : g_prescaler
            localparam logic [C_PRE_W-1:0] C_PRE_LAST = C_PRE_W'(DIV - 1);

            logic [C_PRE_W-1:0] r_pre;

            assign w_pre_last = (r_pre == C_PRE_LAST);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_pre <= '0;
                end else if (load) begin
                    r_pre <= '0;
                end else if (w_run_en) begin
                    r_pre <= w_pre_last ? '0 : r_pre + C_PRE_W'(1);
                end
            end
        end else begin : g_no_prescaler
            assign w_pre_last = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State, counter, mode and pulse registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. A load strobe overrides everything, including a
    // terminal tick on the same edge, so a collision yields a fresh period
    // and no pulse.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_out_nxt   = 1'b0;

        if (load) begin
            w_cnt_nxt   = load_value;
            w_mode_nxt  = periodic;
            w_state_nxt = (load_value != '0) ? S_RUN : S_IDLE;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_tick) begin
                        if (r_cnt > WIDTH'(1)) begin
                            w_cnt_nxt = r_cnt - WIDTH'(1);
                        end else begin
                            // Terminal count: pulse is issued even when the
                            // live reload value turns out to be zero.
                            w_out_nxt = 1'b1;
                            if (r_mode) begin
                                w_cnt_nxt = load_value;
                                if (load_value == '0) begin
                                    w_state_nxt = S_IDLE;
                                end
                            end else begin
                                w_cnt_nxt   = '0;
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    // Only a load leaves these states.
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign out   = r_out;
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign count = r_cnt;

endmodule
`default_nettype wire
